// File: rtl/uart_8n1_if.sv
// Handshake bundle between uart_8n1 and the Apple 1 keyboard/display adapters.
// The adapter side uses the master modport and the transceiver uses slave; rx_state/tx_state are debug taps.
interface uart_8n1_if;
   logic [7:0] rx_data;
   logic       rx_flag;
   logic       rx_ack;
   logic [7:0] tx_data;
   logic       tx_flag;
   logic       tx_wr;
   logic [1:0] rx_state;
   logic [1:0] tx_state;

   // Handshake: rx_flag=1 means an unread byte sits in rx_data; a one-cycle rx_ack consumes it.
   // tx_flag=1 means a one-cycle tx_wr is accepted on that edge; tx_wr while tx_flag=0 is dropped.
   modport master (
      input  rx_data, rx_flag, tx_flag, rx_state, tx_state,
      output rx_ack, tx_data, tx_wr
   );

   modport slave (
      output rx_data, rx_flag, tx_flag, rx_state, tx_state,
      input  rx_ack, tx_data, tx_wr
   );
endinterface

// File: rtl/uart_8n1.sv
// 8N1 serial transceiver with a single rx holding register and an independent tx path.
// Optional macro UART_TX_FIFO_EN inserts a 4-entry transmit FIFO ahead of the tx FSM.
module uart_8n1 #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       eclk,
   input  logic       ereset_n,
   input  logic       rxd,
   output logic       txd,
   uart_8n1_if.slave  bus
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t rx_state;
   state_t tx_state;

   logic          rxd_s1, rxd_s2, rxd_h;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic [7:0]    rx_data_r;
   logic          rx_flag_r;

   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shift;
   logic          tx_flag_r;
   logic          tx_start;
   logic [7:0]    tx_byte;

   // Receive path: sync chain and history flop are preset high so reset never looks like a start edge.
   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         rxd_s1    <= 1'b1;
         rxd_s2    <= 1'b1;
         rxd_h     <= 1'b1;
         rx_state  <= S_IDLE;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_shift  <= '0;
         rx_data_r <= '0;
         rx_flag_r <= 1'b0;
      end else begin
         rxd_s1 <= rxd;
         rxd_s2 <= rxd_s1;
         rxd_h  <= rxd_s2;
         if (bus.rx_ack) rx_flag_r <= 1'b0;
         case (rx_state)
            S_IDLE: begin
               if (rxd_h && !rxd_s2) begin
                  rx_cnt   <= HALF_CNT;
                  rx_state <= S_START;
               end
            end
            S_START: begin
               if (rx_cnt == CNT_ONE) begin
                  if (!rxd_s2) begin
                     rx_cnt   <= BIT_CNT;
                     rx_bit   <= '0;
                     rx_state <= S_DATA;
                  end else begin
                     rx_state <= S_IDLE;
                  end
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            S_DATA: begin
               if (rx_cnt == CNT_ONE) begin
                  rx_shift <= {rxd_s2, rx_shift[7:1]};
                  rx_cnt   <= BIT_CNT;
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == 3'd7) rx_state <= S_STOP;
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            S_STOP: begin
               if (rx_cnt == CNT_ONE) begin
                  // A completing frame overrides a same-cycle rx_ack.
                  if (rxd_s2) begin
                     rx_data_r <= rx_shift;
                     rx_flag_r <= 1'b1;
                  end
                  rx_state <= S_IDLE;
               end else begin
                  rx_cnt <= rx_cnt - CNT_ONE;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   assign bus.rx_data  = rx_data_r;
   assign bus.rx_flag  = rx_flag_r;
   assign bus.rx_state = rx_state;
   assign bus.tx_state = tx_state;

`ifdef UART_TX_FIFO_EN
   logic [7:0] fifo_mem [4];
   logic [1:0] fifo_wptr, fifo_rptr;
   logic [2:0] fifo_cnt;
   logic       fifo_push;

   assign fifo_push   = bus.tx_wr && (fifo_cnt != 3'd4);
   // Popping on the last stop-bit cycle chains frames with no idle gap.
   assign tx_start    = (fifo_cnt != 3'd0) &&
                        (tx_flag_r || (tx_state == S_STOP && tx_cnt == CNT_ONE));
   assign tx_byte     = fifo_mem[fifo_rptr];
   assign bus.tx_flag = (fifo_cnt != 3'd4);

   always_ff @(posedge eclk) begin
      if (fifo_push) fifo_mem[fifo_wptr] <= bus.tx_data;
   end

   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         fifo_wptr <= '0;
         fifo_rptr <= '0;
         fifo_cnt  <= '0;
      end else begin
         if (fifo_push) fifo_wptr <= fifo_wptr + 2'd1;
         if (tx_start)  fifo_rptr <= fifo_rptr + 2'd1;
         case ({fifo_push, tx_start})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end
`else
   assign tx_start    = bus.tx_wr && tx_flag_r;
   assign tx_byte     = bus.tx_data;
   assign bus.tx_flag = tx_flag_r;
`endif

   // Transmit path: tx_flag_r is high exactly while the FSM sits in IDLE.
   always_ff @(posedge eclk or negedge ereset_n) begin
      if (!ereset_n) begin
         tx_state  <= S_IDLE;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
         tx_flag_r <= 1'b1;
         txd       <= 1'b1;
      end else if (tx_start) begin
         tx_shift  <= tx_byte;
         tx_cnt    <= BIT_CNT;
         tx_flag_r <= 1'b0;
         txd       <= 1'b0;
         tx_state  <= S_START;
      end else begin
         case (tx_state)
            S_IDLE: begin
               txd       <= 1'b1;
               tx_flag_r <= 1'b1;
            end
            S_START: begin
               if (tx_cnt == CNT_ONE) begin
                  txd      <= tx_shift[0];
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= '0;
                  tx_cnt   <= BIT_CNT;
                  tx_state <= S_DATA;
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            S_DATA: begin
               if (tx_cnt == CNT_ONE) begin
                  tx_cnt <= BIT_CNT;
                  if (tx_bit == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     txd      <= tx_shift[0];
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            S_STOP: begin
               if (tx_cnt == CNT_ONE) begin
                  tx_flag_r <= 1'b1;
                  tx_state  <= S_IDLE;
               end else begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end
            end
            default: tx_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_8n1.sv
// Directed bench for uart_8n1 at CLKS_PER_BIT=16 in the default (no tx FIFO) build.
// Expected values are hand-computed; tx line bits are queued and popped at mid-bit samples.
module tb_uart_8n1;

   localparam int CPB = 16;

   logic eclk;
   logic ereset_n;
   logic rxd;
   logic txd;

   uart_8n1_if bus ();

   uart_8n1 #(.CLKS_PER_BIT(CPB)) dut (
      .eclk     (eclk),
      .ereset_n (ereset_n),
      .rxd      (rxd),
      .txd      (txd),
      .bus      (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [0:0] exp_q[$];

   // Clock / reset
   initial eclk = 1'b0;
   always #5 eclk = ~eclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      else n_pass++;
   endtask

   // Driver: one tx_wr pulse, then mid-bit samples of txd against the queued frame.
   task automatic send_tx_and_check(input logic [7:0] b, input logic poke);
      int w;
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      exp_q.push_back(1'b1);
      @(negedge eclk);
      bus.tx_data = b;
      bus.tx_wr   = 1'b1;
      @(negedge eclk);
      bus.tx_wr   = 1'b0;
      check("tx_flag_busy", 32'(bus.tx_flag), 32'd0);
      for (int i = 0; i < 10; i++) begin
         w = (i == 0) ? 8 : ((poke && i == 4) ? 15 : 16);
         repeat (w) @(negedge eclk);
         check($sformatf("tx_bit%0d_%02h", i, b), 32'(txd), 32'(exp_q.pop_front()));
         if (poke && i == 3) begin
            bus.tx_data = 8'hFF;
            bus.tx_wr   = 1'b1;
            @(negedge eclk);
            bus.tx_wr   = 1'b0;
         end
      end
      repeat (7) @(negedge eclk);
      check("tx_flag_pre_end", 32'(bus.tx_flag), 32'd0);
      @(negedge eclk);
      check("tx_flag_end", 32'(bus.tx_flag), 32'd1);
      check("tx_idle_line", 32'(txd), 32'd1);
   endtask

   // Driver: one serial frame on rxd; optional rx_ack on the frame's completion edge.
   task automatic send_rx(input logic [7:0] b, input logic stop_bit, input logic ack_at_end);
      @(negedge eclk);
      rxd = 1'b0;
      repeat (CPB) @(negedge eclk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge eclk);
      end
      rxd = stop_bit;
      repeat (10) @(negedge eclk);
      if (ack_at_end) bus.rx_ack = 1'b1;
      @(negedge eclk);
      bus.rx_ack = 1'b0;
      repeat (5) @(negedge eclk);
      rxd = 1'b1;
      repeat (4) @(negedge eclk);
   endtask

   task automatic pulse_ack();
      @(negedge eclk);
      bus.rx_ack = 1'b1;
      @(negedge eclk);
      bus.rx_ack = 1'b0;
   endtask

   initial begin
      int bad;
      ereset_n    = 1'b0;
      rxd         = 1'b1;
      bus.rx_ack  = 1'b0;
      bus.tx_wr   = 1'b0;
      bus.tx_data = 8'h00;
      repeat (5) @(negedge eclk);
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_tx_flag", 32'(bus.tx_flag), 32'd1);
      check("rst_rx_flag", 32'(bus.rx_flag), 32'd0);
      check("rst_rx_data", 32'(bus.rx_data), 32'h00);
      ereset_n = 1'b1;

      bad = 0;
      repeat (1000) begin
         @(negedge eclk);
         if (txd !== 1'b1 || bus.tx_flag !== 1'b1 || bus.rx_flag !== 1'b0 || bus.rx_data !== 8'h00) bad++;
      end
      check("idle_1000_cycles", 32'(bad), 32'd0);

      // A5 frame with an ignored write in the middle
      send_tx_and_check(8'hA5, 1'b1);

      send_rx(8'h8D, 1'b1, 1'b0);
      check("rx_8d_data", 32'(bus.rx_data), 32'h8D);
      check("rx_8d_flag", 32'(bus.rx_flag), 32'd1);
      pulse_ack();
      check("rx_ack_clear", 32'(bus.rx_flag), 32'd0);

      @(negedge eclk);
      rxd = 1'b0;
      repeat (4) @(negedge eclk);
      rxd = 1'b1;
      repeat (40) @(negedge eclk);
      check("false_start_flag", 32'(bus.rx_flag), 32'd0);
      check("false_start_data", 32'(bus.rx_data), 32'h8D);
      check("false_start_state", 32'(bus.rx_state), 32'd0);

      send_rx(8'h55, 1'b0, 1'b0);
      repeat (20) @(negedge eclk);
      check("framing_err_flag", 32'(bus.rx_flag), 32'd0);
      check("framing_err_data", 32'(bus.rx_data), 32'h8D);

      send_rx(8'h41, 1'b1, 1'b0);
      send_rx(8'h42, 1'b1, 1'b0);
      check("overrun_data", 32'(bus.rx_data), 32'h42);
      check("overrun_flag", 32'(bus.rx_flag), 32'd1);
      send_rx(8'h43, 1'b1, 1'b1);
      check("ack_vs_done_data", 32'(bus.rx_data), 32'h43);
      check("ack_vs_done_flag", 32'(bus.rx_flag), 32'd1);
      pulse_ack();
      check("ack_clear_43", 32'(bus.rx_flag), 32'd0);
      pulse_ack();
      check("ack_no_effect_flag", 32'(bus.rx_flag), 32'd0);
      check("ack_no_effect_data", 32'(bus.rx_data), 32'h43);

      // Full duplex: rx and tx frames overlap
      fork
         send_rx(8'h7E, 1'b1, 1'b0);
         send_tx_and_check(8'h3C, 1'b0);
      join
      check("duplex_rx_data", 32'(bus.rx_data), 32'h7E);
      check("duplex_rx_flag", 32'(bus.rx_flag), 32'd1);

      // Reset in the middle of a tx frame and with an unread rx byte held
      @(negedge eclk);
      bus.tx_data = 8'hC3;
      bus.tx_wr   = 1'b1;
      @(negedge eclk);
      bus.tx_wr   = 1'b0;
      repeat (40) @(negedge eclk);
      check("pre_reset_txd", 32'(txd), 32'd1);
      check("pre_reset_busy", 32'(bus.tx_flag), 32'd0);
      ereset_n = 1'b0;
      #1;
      check("mid_rst_txd", 32'(txd), 32'd1);
      check("mid_rst_tx_flag", 32'(bus.tx_flag), 32'd1);
      check("mid_rst_rx_flag", 32'(bus.rx_flag), 32'd0);
      check("mid_rst_rx_data", 32'(bus.rx_data), 32'h00);
      @(negedge eclk);
      ereset_n = 1'b1;
      bad = 0;
      repeat (200) begin
         @(negedge eclk);
         if (txd !== 1'b1 || bus.tx_flag !== 1'b1 || bus.rx_flag !== 1'b0) bad++;
      end
      check("post_rst_quiet", 32'(bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
